// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART TX frame scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEF_DBITS       = 8;
    localparam int DEF_FRAME_BYTES = 4;

    // Counter width able to hold values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the previous owner.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = IDX_W'((int'(last_owner) + off) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Grants whole frames to requesters round-robin, feeds them to the TX FIFO and
// tracks byte completion with a per-byte watchdog and an inter-frame guard gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DBITS       = DEF_DBITS,
    parameter int FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 16
) (
    input  logic                               clk_100MHz,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*FRAME_BYTES*DBITS-1:0] req_data,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_REQ-1:0]                 done,
    output logic                               tx_trigger,
    output logic [FRAME_BYTES*DBITS-1:0]       tx_in,
    input  logic                               tx_byte_done,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int FRAME_W = FRAME_BYTES * DBITS;
    localparam int IDX_W   = clog2_min1(NUM_REQ);
    localparam int CNT_W   = clog2_min1(FRAME_BYTES + 1);
    localparam int TMR_W   = clog2_min1(TIMEOUT_CYC);
    localparam int GAP_W   = clog2_min1(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);
    // Abort is decided one cycle early so the timer shows TIMEOUT_CYC-1 alongside done.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC >= 2) ? TIMEOUT_CYC - 2 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC >= 1) ? GAP_CYC - 1 : 0);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_trigger;
    logic [FRAME_W-1:0] r_tx_in;
    logic               r_busy;
    logic               r_timeout;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_bd_d;

    logic [NUM_REQ-1:0] w_winner;
    logic [IDX_W-1:0]   w_win_idx;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [FRAME_W-1:0] w_slice [NUM_REQ];
    logic               w_count;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .last_owner (r_owner),
        .winner     (w_winner)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_slice[gi]    = req_data[gi*FRAME_W +: FRAME_W];
        assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
    end

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end

    // Rising edges only; an edge coinciding with the FIFO load strobe belongs to no frame.
    assign w_count = (r_state == ST_SEND) && tx_byte_done && !r_bd_d && !r_trigger;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_done     <= '0;
            r_trigger  <= 1'b0;
            r_tx_in    <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_owner    <= IDX_W'(NUM_REQ - 1);
            r_byte_cnt <= '0;
            r_timer    <= '0;
            r_gap_cnt  <= '0;
            r_bd_d     <= 1'b0;
        end else begin
            r_bd_d    <= tx_byte_done;
            r_grant   <= '0;
            r_done    <= '0;
            r_trigger <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= w_winner;
                        r_tx_in <= w_slice[w_win_idx];
                        r_owner <= w_win_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_trigger  <= 1'b1;
                    r_byte_cnt <= '0;
                    r_timer    <= '0;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_count) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_timer    <= '0;
                        if (r_byte_cnt == CNT_LAST) begin
                            r_done    <= w_owner_oh;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (r_timer == TMR_LAST) begin
                            r_done    <= w_owner_oh;
                            r_timeout <= 1'b1;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign tx_trigger  = r_trigger;
    assign tx_in       = r_tx_in;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single frame, fairness, stretched byte-done,
// timeout, mid-frame reset and inter-frame gap timing.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int DBITS       = 8;
    localparam int FRAME_BYTES = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int GAP_CYC     = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         tx_trigger;
    logic [31:0]  tx_in;
    logic         tx_byte_done = 1'b0;
    logic         busy;
    logic         timeout_err;

    logic [31:0] exp_data [4];
    logic [3:0]  exp_order [5];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_grant = 0, n_done = 0, n_trig = 0, n_to = 0;
    int done_cyc = 0, to_cyc = 0, edge_cyc = 0;
    logic [3:0] last_done = '0;

    uart_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .DBITS       (DBITS),
        .FRAME_BYTES (FRAME_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk_100MHz   (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .done         (done),
        .tx_trigger   (tx_trigger),
        .tx_in        (tx_in),
        .tx_byte_done (tx_byte_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (grant != '0) n_grant++;
        if (tx_trigger) n_trig++;
        if (done != '0) begin
            n_done++;
            done_cyc  = cyc;
            last_done = done;
        end
        if (timeout_err) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic byte_pulse(input int hold);
        tx_byte_done = 1'b1;
        edge_cyc     = cyc;
        step(hold);
        tx_byte_done = 1'b0;
        step(3);
    endtask

    task automatic wait_grant(input string tag);
        int k = 0;
        while (grant == '0 && k < 200) begin
            step(1);
            k++;
        end
        if (grant == '0) chk({tag, "_wait"}, 32'd0, 32'd1);
    endtask

    initial begin
        int base_done, base_trig, base_to, base_grant, k, d;

        exp_data[0] = 32'hA1B2C3D4;
        exp_data[1] = 32'h11223344;
        exp_data[2] = 32'h55667788;
        exp_data[3] = 32'h99AABBCC;
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        req_data = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

        // Reset state
        step(3);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig", 32'(tx_trigger), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        chk("rst_txin", tx_in, 32'd0);

        // Single request, grant in the first cycle after reset release
        reset_n = 1'b1;
        req     = 4'b0001;
        step(1);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_txin", tx_in, 32'hA1B2C3D4);
        chk("single_busy", 32'(busy), 32'd1);
        req = '0;
        step(1);
        chk("single_trig", 32'(tx_trigger), 32'd1);
        chk("single_grant_off", 32'(grant), 32'd0);
        step(1);
        chk("single_trig_off", 32'(tx_trigger), 32'd0);
        base_done = n_done;
        for (int b = 0; b < 3; b++) byte_pulse(1);
        chk("single_early_done", 32'(n_done - base_done), 32'd0);
        byte_pulse(1);
        chk("single_done_cnt", 32'(n_done - base_done), 32'd1);
        chk("single_done_vec", 32'(last_done), 32'h1);
        chk("single_no_to", 32'(n_to), 32'd0);
        step(20);
        chk("single_idle", 32'(busy), 32'd0);

        // Fairness from a fresh reset with all requesters held high
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        req     = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_grant($sformatf("fair%0d", f));
            chk($sformatf("fair%0d_grant", f), 32'(grant), 32'(exp_order[f]));
            chk($sformatf("fair%0d_txin", f), tx_in, exp_data[f % 4]);
            step(2);
            for (int b = 0; b < 4; b++) byte_pulse(1);
        end
        req = '0;
        step(25);

        // Stretched byte-done: each 5-cycle-high pulse counts once
        req = 4'b0001;
        wait_grant("stretch");
        chk("stretch_grant", 32'(grant), 32'h1);
        req = '0;
        step(2);
        base_done = n_done;
        for (int b = 0; b < 3; b++) byte_pulse(5);
        chk("stretch_early_done", 32'(n_done - base_done), 32'd0);
        byte_pulse(5);
        chk("stretch_done_cnt", 32'(n_done - base_done), 32'd1);
        chk("stretch_done_vec", 32'(last_done), 32'h1);

        // Request withdrawn during the gap is never granted
        base_grant = n_grant;
        req = 4'b1000;
        step(4);
        req = '0;
        step(25);
        chk("withdraw_grants", 32'(n_grant - base_grant), 32'd0);
        chk("withdraw_busy", 32'(busy), 32'd0);

        // Timeout after two bytes
        req = 4'b0100;
        wait_grant("timeout");
        chk("timeout_grant", 32'(grant), 32'h4);
        req = '0;
        step(2);
        base_done = n_done;
        base_to   = n_to;
        byte_pulse(1);
        byte_pulse(1);
        k = 0;
        while (n_done == base_done && k < 200) begin
            step(1);
            k++;
        end
        chk("timeout_done_cnt", 32'(n_done - base_done), 32'd1);
        chk("timeout_err_cnt", 32'(n_to - base_to), 32'd1);
        chk("timeout_delay", 32'(to_cyc - edge_cyc), 32'd64);
        chk("timeout_coincide", 32'(done_cyc), 32'(to_cyc));
        chk("timeout_done_vec", 32'(last_done), 32'h4);
        step(25);

        // Reset in the middle of SEND
        req = 4'b0010;
        wait_grant("midrst");
        chk("midrst_grant", 32'(grant), 32'h2);
        req = '0;
        step(2);
        byte_pulse(1);
        byte_pulse(1);
        base_done = n_done;
        base_trig = n_trig;
        reset_n   = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_trig", 32'(tx_trigger), 32'd0);
        chk("midrst_txin", tx_in, 32'd0);
        step(3);
        reset_n = 1'b1;
        step(5);
        chk("midrst_no_done", 32'(n_done - base_done), 32'd0);
        chk("midrst_no_trig", 32'(n_trig - base_trig), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        req = 4'b1111;
        wait_grant("postrst");
        chk("postrst_grant", 32'(grant), 32'h1);

        // Gap enforcement with requests held through done
        step(2);
        for (int b = 0; b < 4; b++) byte_pulse(1);
        d = done_cyc;
        wait_grant("gap");
        chk("gap_grant", 32'(grant), 32'h2);
        chk("gap_latency", 32'(cyc - d), 32'd17);
        req = '0;
        step(2);
        for (int b = 0; b < 4; b++) byte_pulse(1);
        chk("gap_done_vec", 32'(last_done), 32'h2);
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of frame requesters.
REQ-002 Parameter DBITS, default 8: bits per UART word.
REQ-003 Parameter FRAME_BYTES, default 4: bytes per frame; equals the TX batch FIFO depth.
REQ-004 Parameter TIMEOUT_CYC, default 4096: maximum clock cycles allowed between byte-done edges.
REQ-005 Parameter GAP_CYC, default 16: idle guard cycles inserted between frames.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 Port clk_100MHz, input, 1: system clock.
REQ-008 Port reset_n, input, 1: asynchronous active-low reset.
REQ-009 Port req, input, NUM_REQ: per-requester level request; held high until granted.
REQ-010 Port req_data, input, NUM_REQ*FRAME_BYTES*DBITS: per-requester frame, where requester i occupies slice i.
REQ-011 Port grant, output, NUM_REQ: one-hot, one-cycle pulse accepting a frame.
REQ-012 Port done, output, NUM_REQ: one-hot, one-cycle pulse when the granted frame finishes or aborts.
REQ-013 Port tx_trigger, output, 1: one-cycle batch load strobe to the TX FIFO.
REQ-014 Port tx_in, output, FRAME_BYTES*DBITS: batch frame data to the TX FIFO.
REQ-015 Port tx_byte_done, input, 1: transmitter byte-complete flag; may be high for multiple cycles.
REQ-016 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-017 Port timeout_err, output, 1: one-cycle pulse, coincident with done, when a frame is aborted.

Function
REQ-018 FSM states: IDLE, LOAD, SEND, GAP.
REQ-019 IDLE: if any req bit is high, select a winner by round-robin, pulse grant[winner], register its req_data slice into tx_in, record the owner, and go to LOAD; if no req bit is high, remain in IDLE.
REQ-020 Round-robin: search starts at (last_owner+1) mod NUM_REQ; after reset last_owner = NUM_REQ-1, so requester 0 has priority first.
REQ-021 LOAD: assert tx_trigger for exactly one cycle, clear the byte counter and the timeout timer, then go to SEND.
REQ-022 tx_in holds the registered frame, stable from LOAD until the next grant.
REQ-023 SEND: the byte counter increments once per rising edge of tx_byte_done, detected against a registered copy; a level held high counts once.
REQ-024 A tx_byte_done edge arriving in the same cycle as tx_trigger is ignored.
REQ-025 SEND completion: when the counter reaches FRAME_BYTES, pulse done[owner] and go to GAP.
REQ-026 SEND timeout: the timer resets on each counted edge; when it reaches TIMEOUT_CYC-1, pulse done[owner] and timeout_err together and go to GAP.
REQ-027 GAP: count GAP_CYC cycles, then return to IDLE; req is ignored during GAP; GAP_CYC=0 returns to IDLE on the next cycle.
REQ-028 Latency: grant to tx_trigger is exactly 1 cycle; a new grant is issued no earlier than GAP_CYC+1 cycles after done.
REQ-029 A requester dropping req before grant is not granted and causes no error.
REQ-030 Counter widths: $clog2(FRAME_BYTES+1), $clog2(TIMEOUT_CYC), and $clog2(GAP_CYC+1), each with a minimum of 1 bit.

Reset
REQ-031 While reset_n is low: state = IDLE; grant, done, tx_trigger, busy, and timeout_err = 0; tx_in = 0; all counters = 0; last_owner = NUM_REQ-1.
REQ-032 Reset asserted mid-frame aborts the frame with no done pulse, and no tx_trigger is issued on deassertion.
REQ-033 The first grant can occur in the first cycle after reset_n rises.

Structure
REQ-034 FSM state encodings and the default DBITS/FRAME_BYTES constants reside in the shared package uart_pkg.
REQ-035 Round-robin selection is one sub-module, rr_arbiter (inputs req and last_owner; output one-hot winner), and is purely combinational.
REQ-036 All other logic is in uart_tx_scheduler; there are no latches and no derived clocks.

Verification
REQ-037 Single request: req=4'b0001, req_data[31:0]=32'hA1B2C3D4 -> grant=0001 in cycle 1, tx_trigger in cycle 2, tx_in=32'hA1B2C3D4; after 4 byte-done edges, done=0001.
REQ-038 Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0 across five frames.
REQ-039 Stretched byte-done: tx_byte_done held high 5 cycles per byte -> each byte counted once, and done fires after exactly 4 pulses.
REQ-040 Timeout: TIMEOUT_CYC=64, only 2 byte-done edges supplied -> 64 cycles after the last edge, done and timeout_err pulse together, then GAP.
REQ-041 Reset mid-SEND: reset_n low for 3 cycles after byte 2 -> all outputs 0, no done pulse; the next grant goes to requester 0.
REQ-042 Gap enforcement: GAP_CYC=16, req re-asserted at done -> next grant exactly 17 cycles after done.
